mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one memory instance (r_en/r_addr/r_data + w_en/w_addr/w_data) between the core's
//  instruction-fetch port (read-only) and data port (read/write). One access in flight at a time,
//  req/ack handshake per requester, data priority with bounded instruction starvation.
//  Sits between core and a single unified memory in toplevel.
// PARAMETERS
//  ADDR_W    32  address width, all ports
//  DATA_W    32  data width, all ports
//  READ_LAT  1   memory read latency: r_data valid READ_LAT cycles after the r_en cycle (>=1)
//  MAX_WAIT  4   max consecutive lost arbitrations for instr before it takes priority (>=1)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  instr_req    in   1       instr read request; hold with instr_addr stable until instr_ack
//  instr_addr   in   ADDR_W  instr read address
//  instr_ack    out  1       1-cycle pulse: access complete, instr_rdata valid this cycle
//  instr_rdata  out  DATA_W  instr read data
//  data_req     in   1       data request; hold with data_we/addr/wdata stable until data_ack
//  data_we      in   1       1 = write, 0 = read
//  data_addr    in   ADDR_W  data address
//  data_wdata   in   DATA_W  write data
//  data_ack     out  1       1-cycle pulse: access complete (read: data_rdata valid this cycle)
//  data_rdata   out  DATA_W  data read data
//  mem_r_en     out  1       memory read enable
//  mem_r_addr   out  ADDR_W  memory read address
//  mem_r_data   in   DATA_W  memory read data
//  mem_w_en     out  1       memory write enable
//  mem_w_addr   out  ADDR_W  memory write address
//  mem_w_data   out  DATA_W  memory write data
//  owner        out  2       current owner: 00 none, 01 instr, 10 data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 incl. rdata, addr/data regs, owner; wait_cnt 0.
//  - All outputs registered. FSM: IDLE -> ACCESS -> [WAIT x READ_LAT, reads only] -> DONE -> IDLE.
//  - IDLE (T0): sample reqs. Winner: data if data_req and (!instr_req or wait_cnt<MAX_WAIT);
//    else instr if instr_req. Latch winner's addr/we/wdata; owner set; go ACCESS. No req: stay.
//  - ACCESS (T1): exactly one cycle of mem_r_en (read) or mem_w_en (write) with latched addr/data.
//    Enables never both high; mem_*_addr/mem_w_data hold last value when enable low.
//  - WAIT: READ_LAT cycles; mem_r_data captured into winner's rdata reg at end of last WAIT cycle.
//  - DONE: winner's ack=1 for one cycle; loser ack stays 0; non-winner rdata unchanged. Next IDLE.
//  - Latency req-sampled(T0) to ack: read 2+READ_LAT cycles, write 2 cycles.
//  - Requester may present a new (or same) request in the cycle after ack; IDLE samples it as new.
//    req held high through DONE never causes a duplicate access.
//  - wait_cnt: in IDLE, +1 (saturate MAX_WAIT) when instr_req and data wins; clear when instr wins.
//  - Simultaneous reqs with wait_cnt==MAX_WAIT: instr wins, wait_cnt -> 0.
//  - req dropped before ack: protocol violation; in-flight access still completes and acks.
//  - rst mid-access (any state): next cycle IDLE, all outputs 0, no ack for aborted access;
//    write already issued in ACCESS is not undone.
//  - owner == 00 only in IDLE.
// TESTING
//  1 READ_LAT=1, instr_req addr 0x10, mem returns 0xDEADBEEF -> mem_r_en one cycle at T1 addr 0x10;
//    instr_ack at T3 with instr_rdata=0xDEADBEEF; data_ack stays 0.
//  2 data write addr 0x20 wdata 0x12345678 -> mem_w_en one cycle at T1 with 0x20/0x12345678,
//    mem_r_en never high, data_ack at T2.
//  3 both reqs held continuously, MAX_WAIT=4 -> grant order D,D,D,D,I repeating; instr never waits
//    more than 4 grants; owner matches each grant.
//  4 back-to-back data reads at 0x0,0x4,0x8 presented cycle after each ack -> mem_r_en every
//    3+READ_LAT cycles, 3 acks, rdata in order, no duplicate/missed access.
//  5 rst asserted during WAIT of instr read -> next cycle IDLE, all outputs 0, no instr_ack;
//    subsequent data read completes normally.
//  6 READ_LAT=3 instr read -> mem_r_en at T1, instr_ack at T5 with data sampled at end of T4.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle between the core's instruction/data ports, the arbiter and the shared memory.
// The slave view belongs to the arbiter; the master view to the core and memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ack;
  logic [DATA_W-1:0] instr_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_r_data;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_w_data;

  logic [1:0]        owner;

  modport slave (
    input  instr_req, instr_addr, data_req, data_we, data_addr, data_wdata, mem_r_data,
    output instr_ack, instr_rdata, data_ack, data_rdata,
           mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data, owner
  );

  modport master (
    output instr_req, instr_addr, data_req, data_we, data_addr, data_wdata, mem_r_data,
    input  instr_ack, instr_rdata, data_ack, data_rdata,
           mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between instruction fetch (read-only) and data (read/write) ports.
// Data has priority; instruction fetch takes over after MAX_WAIT consecutive lost arbitrations.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              we_reg;
  logic [1:0]        owner_reg;
  logic              instr_ack_reg;
  logic              data_ack_reg;
  logic [DATA_W-1:0] instr_rdata_reg;
  logic [DATA_W-1:0] data_rdata_reg;
  logic              mem_r_en_reg;
  logic [ADDR_W-1:0] mem_r_addr_reg;
  logic              mem_w_en_reg;
  logic [ADDR_W-1:0] mem_w_addr_reg;
  logic [DATA_W-1:0] mem_w_data_reg;

  logic grant_data;
  logic grant_instr;

  always_comb begin
    grant_data  = bus.data_req && (!bus.instr_req || (wait_cnt_reg < WAIT_W'(MAX_WAIT)));
    grant_instr = bus.instr_req && !grant_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      lat_cnt_reg     <= '0;
      wait_cnt_reg    <= '0;
      we_reg          <= 1'b0;
      owner_reg       <= 2'b00;
      instr_ack_reg   <= 1'b0;
      data_ack_reg    <= 1'b0;
      instr_rdata_reg <= '0;
      data_rdata_reg  <= '0;
      mem_r_en_reg    <= 1'b0;
      mem_r_addr_reg  <= '0;
      mem_w_en_reg    <= 1'b0;
      mem_w_addr_reg  <= '0;
      mem_w_data_reg  <= '0;
    end else begin
      instr_ack_reg <= 1'b0;
      data_ack_reg  <= 1'b0;
      mem_r_en_reg  <= 1'b0;
      mem_w_en_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Enables are launched here so they are high during the ACCESS cycle itself.
          if (grant_data) begin
            state_reg <= ACCESS;
            owner_reg <= 2'b10;
            we_reg    <= bus.data_we;
            if (bus.data_we) begin
              mem_w_en_reg   <= 1'b1;
              mem_w_addr_reg <= bus.data_addr;
              mem_w_data_reg <= bus.data_wdata;
            end else begin
              mem_r_en_reg   <= 1'b1;
              mem_r_addr_reg <= bus.data_addr;
            end
            // Data only beats a waiting fetch while wait_cnt < MAX_WAIT, so this cannot overflow.
            if (bus.instr_req) wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end else if (grant_instr) begin
            state_reg      <= ACCESS;
            owner_reg      <= 2'b01;
            we_reg         <= 1'b0;
            mem_r_en_reg   <= 1'b1;
            mem_r_addr_reg <= bus.instr_addr;
            wait_cnt_reg   <= '0;
          end
        end
        ACCESS: begin
          if (we_reg) begin
            state_reg    <= DONE;
            data_ack_reg <= 1'b1;
          end else begin
            state_reg   <= WAIT;
            lat_cnt_reg <= LAT_W'(READ_LAT - 1);
          end
        end
        WAIT: begin
          if (lat_cnt_reg == '0) begin
            state_reg <= DONE;
            if (owner_reg[1]) begin
              data_rdata_reg <= bus.mem_r_data;
              data_ack_reg   <= 1'b1;
            end else begin
              instr_rdata_reg <= bus.mem_r_data;
              instr_ack_reg   <= 1'b1;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          owner_reg <= 2'b00;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.instr_ack   = instr_ack_reg;
  assign bus.instr_rdata = instr_rdata_reg;
  assign bus.data_ack    = data_ack_reg;
  assign bus.data_rdata  = data_rdata_reg;
  assign bus.mem_r_en    = mem_r_en_reg;
  assign bus.mem_r_addr  = mem_r_addr_reg;
  assign bus.mem_w_en    = mem_w_en_reg;
  assign bus.mem_w_addr  = mem_w_addr_reg;
  assign bus.mem_w_data  = mem_w_data_reg;
  assign bus.owner       = owner_reg;
endmodule
